// File: rtl/hyperram_responder_if.sv
// Pre-split HyperRAM pin bundle between a host (master) and the responder (slave).
// cs_n low frames a transaction; there is no valid/ready: every clk with cs_n low carries one word.
interface hyperram_responder_if;
   logic       cs_n;
   logic [7:0] dq_in_ris;
   logic [7:0] dq_in_fal;
   logic       rwds_in_ris;
   logic       rwds_in_fal;
   logic       refresh_req;
   logic [7:0] dq_out_ris;
   logic [7:0] dq_out_fal;
   logic       dq_oe;
   logic       rwds_out_ris;
   logic       rwds_out_fal;
   logic       rwds_oe;

   modport master (
      output cs_n, dq_in_ris, dq_in_fal, rwds_in_ris, rwds_in_fal, refresh_req,
      input  dq_out_ris, dq_out_fal, dq_oe, rwds_out_ris, rwds_out_fal, rwds_oe
   );

   modport slave (
      input  cs_n, dq_in_ris, dq_in_fal, rwds_in_ris, rwds_in_fal, refresh_req,
      output dq_out_ris, dq_out_fal, dq_oe, rwds_out_ris, rwds_out_fal, rwds_oe
   );
endinterface

// File: rtl/hyperram_responder.sv
// HyperRAM device-side responder: CA decode, latency counting, memory and CR0 access.
// Define HYPERRAM_RESP_VARLAT_EN to allow 1x latency; otherwise latency is always 2x.
module hyperram_responder #(
   parameter int          ADDR_W   = 12,
   parameter logic [15:0] INIT_CR0 = 16'h8F1F
) (
   input  logic                clk,
   input  logic                resetn,
   hyperram_responder_if.slave bus,
   output logic [15:0]         cr0,
   output logic                active,
   output logic [2:0]          dbg_state
);
   typedef enum logic [2:0] {IDLE, CA, LAT, RDATA, WDATA, REGW} state_t;

   state_t            state_q, state_n;
   logic [3:0]        cnt_q, cnt_n, d_q, d_n;
   logic [31:0]       ca_q, ca_n;
   logic              is_rd_q, is_rd_n, is_reg_q, is_reg_n, sel_q, sel_n, m2_q, m2_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [15:0]       cr0_q, cr0_n;
   logic [15:0]       mem [2**ADDR_W];
   logic              mem_we;
   logic [7:0]        dq_ris_q, dq_ris_n, dq_fal_q, dq_fal_n;
   logic              dq_oe_q, dq_oe_n, rw_ris_q, rw_ris_n, rw_fal_q, rw_fal_n, rw_oe_q, rw_oe_n;
   logic [47:0]       full_ca;
   logic [31:0]       word_addr;
   logic              m_sel;
   logic [2:0]        lat;
   logic [15:0]       rd_word;
   logic              ca_unused;

   // The third CA word is consumed combinationally on the edge it arrives.
   assign full_ca   = {ca_q, bus.dq_in_ris, bus.dq_in_fal};
   assign word_addr = {full_ca[44:16], full_ca[2:0]};
   assign rd_word   = is_reg_q ? (sel_q ? 16'h0000 : cr0) : mem[addr_q];

`ifdef HYPERRAM_RESP_VARLAT_EN
   assign m_sel     = cr0_q[3] | bus.refresh_req;
   assign cr0       = cr0_q;
   assign ca_unused = ^{full_ca[45], full_ca[15:3], word_addr[31:ADDR_W]};
`else
   assign m_sel     = 1'b1;
   assign cr0       = cr0_q | 16'h0008;
   assign ca_unused = ^{full_ca[45], full_ca[15:3], word_addr[31:ADDR_W], bus.refresh_req};
`endif

   always_comb begin
      case (cr0_q[7:4])
         4'hE:    lat = 3'd3;
         4'hF:    lat = 3'd4;
         4'h0:    lat = 3'd5;
         default: lat = 3'd6;
      endcase
   end

   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      ca_n     = ca_q;
      is_rd_n  = is_rd_q;
      is_reg_n = is_reg_q;
      sel_n    = sel_q;
      m2_n     = m2_q;
      d_n      = d_q;
      addr_n   = addr_q;
      cr0_n    = cr0_q;
      mem_we   = 1'b0;
      dq_ris_n = 8'h00;
      dq_fal_n = 8'h00;
      dq_oe_n  = 1'b0;
      rw_ris_n = 1'b0;
      rw_fal_n = 1'b0;
      rw_oe_n  = 1'b0;
      if (bus.cs_n) begin
         state_n = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // Latency and multiplier are frozen here so a CR0 write only affects later transactions.
               state_n  = CA;
               cnt_n    = 4'd1;
               ca_n     = {bus.dq_in_ris, bus.dq_in_fal, 16'h0000};
               m2_n     = m_sel;
               d_n      = 4'd2 + (m_sel ? {lat, 1'b0} : {1'b0, lat});
               rw_oe_n  = 1'b1;
               rw_ris_n = m_sel;
               rw_fal_n = m_sel;
            end
            CA: begin
               rw_oe_n  = 1'b1;
               rw_ris_n = m2_q;
               rw_fal_n = m2_q;
               if (cnt_q == 4'd1) begin
                  ca_n[15:0] = {bus.dq_in_ris, bus.dq_in_fal};
                  cnt_n      = 4'd2;
               end else begin
                  is_rd_n  = full_ca[47];
                  is_reg_n = full_ca[46];
                  sel_n    = full_ca[0];
                  addr_n   = word_addr[ADDR_W-1:0];
                  cnt_n    = 4'd3;
                  state_n  = (!full_ca[47] && full_ca[46]) ? REGW : LAT;
               end
            end
            LAT: begin
               cnt_n = cnt_q + 4'd1;
               if (cnt_q == d_q - 4'd1) state_n = is_rd_q ? RDATA : WDATA;
            end
            RDATA: begin
               dq_oe_n  = 1'b1;
               dq_ris_n = rd_word[15:8];
               dq_fal_n = rd_word[7:0];
               rw_oe_n  = 1'b1;
               rw_ris_n = 1'b1;
               addr_n   = addr_q + 1'b1;
            end
            WDATA: begin
               mem_we = 1'b1;
               addr_n = addr_q + 1'b1;
            end
            REGW: begin
               // Only the first data word counts; cnt parks at 4 so the rest are ignored.
               if (cnt_q == 4'd3) begin
                  cnt_n = 4'd4;
                  if (!sel_q) cr0_n = {bus.dq_in_ris, bus.dq_in_fal};
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         d_q      <= 4'd0;
         ca_q     <= 32'h0;
         is_rd_q  <= 1'b0;
         is_reg_q <= 1'b0;
         sel_q    <= 1'b0;
         m2_q     <= 1'b0;
         addr_q   <= '0;
         cr0_q    <= INIT_CR0;
         dq_ris_q <= 8'h00;
         dq_fal_q <= 8'h00;
         dq_oe_q  <= 1'b0;
         rw_ris_q <= 1'b0;
         rw_fal_q <= 1'b0;
         rw_oe_q  <= 1'b0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         d_q      <= d_n;
         ca_q     <= ca_n;
         is_rd_q  <= is_rd_n;
         is_reg_q <= is_reg_n;
         sel_q    <= sel_n;
         m2_q     <= m2_n;
         addr_q   <= addr_n;
         cr0_q    <= cr0_n;
         dq_ris_q <= dq_ris_n;
         dq_fal_q <= dq_fal_n;
         dq_oe_q  <= dq_oe_n;
         rw_ris_q <= rw_ris_n;
         rw_fal_q <= rw_fal_n;
         rw_oe_q  <= rw_oe_n;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && mem_we) begin
         if (!bus.rwds_in_ris) mem[addr_q][15:8] <= bus.dq_in_ris;
         if (!bus.rwds_in_fal) mem[addr_q][7:0]  <= bus.dq_in_fal;
      end
   end

   assign bus.dq_out_ris   = dq_ris_q;
   assign bus.dq_out_fal   = dq_fal_q;
   assign bus.dq_oe        = dq_oe_q;
   assign bus.rwds_out_ris = rw_ris_q;
   assign bus.rwds_out_fal = rw_fal_q;
   assign bus.rwds_oe      = rw_oe_q;
   assign active           = (state_q != IDLE);
   assign dbg_state        = state_q;
endmodule
